// File: rtl/sc_proc_fetch.sv
// Instruction fetch unit: holds the PC, requests words from instruction memory,
// presents them to the datapath and computes the next PC when the instruction retires.
module sc_proc_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0040,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] iword,
  output logic        iwordValid,
  input  logic        instrDone,
  input  logic [1:0]  PCSel,
  input  logic [15:0] imm,
  input  logic [31:0] regOut0,
  output logic [31:0] pcPlus4,
  output logic        fault,
  output logic [1:0]  state
);

  // Handshakes: imemReq stays high with imemAddr stable until a cycle with imemAck;
  // iwordValid stays high with iword/pcPlus4 stable until a cycle with instrDone.
  // Either input is ignored outside the state that waits for it.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int unsigned     CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_iword;
  logic          r_req;
  logic          r_valid;
  logic          r_fault;
  logic [CW-1:0] r_cnt;

  logic [31:0]   w_off;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_next_pc;
  logic          w_bad_next;

  // Word offset is the sign-extended immediate scaled by 4.
  always_comb begin
    w_off      = {{14{imm[15]}}, imm, 2'b00};
    w_pc_plus4 = r_pc + 32'd4;
    case (PCSel)
      2'b01:   w_next_pc = w_pc_plus4 + w_off;
      2'b10:   w_next_pc = regOut0 + w_off;
      default: w_next_pc = w_pc_plus4;
    endcase
    w_bad_next = (PCSel == 2'b11) || (w_next_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_iword <= 32'd0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_cnt   <= '0;
        end
        S_REQ: begin
          if (imemAck) begin
            r_iword <= imemData;
            r_state <= S_ISSUE;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_fault <= 1'b1;
            r_state <= S_HALT;
            r_req   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ISSUE: begin
          if (instrDone) begin
            r_valid <= 1'b0;
            if (w_bad_next) begin
              r_fault <= 1'b1;
              r_state <= S_HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_cnt   <= '0;
            end
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imemAddr   = r_pc;
  assign imemReq    = r_req;
  assign iword      = r_iword;
  assign iwordValid = r_valid;
  assign pcPlus4    = w_pc_plus4;
  assign fault      = r_fault;
  assign state      = r_state;

endmodule

// File: tb/tb_sc_proc_fetch.sv
// Bench for sc_proc_fetch: directed corner cases followed by a randomized
// instruction stream checked against a transaction-level PC model.
module tb_sc_proc_fetch;

  localparam logic [31:0] RESET_PC    = 32'h0000_0040;
  localparam int          ACK_TIMEOUT = 16;
  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_HALT     = 2'd3;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] iword;
  logic        iwordValid;
  logic        instrDone;
  logic [1:0]  PCSel;
  logic [15:0] imm;
  logic [31:0] regOut0;
  logic [31:0] pcPlus4;
  logic        fault;
  logic [1:0]  state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sc_proc_fetch #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imemAddr(imemAddr), .imemReq(imemReq), .imemAck(imemAck), .imemData(imemData),
    .iword(iword), .iwordValid(iwordValid), .instrDone(instrDone), .PCSel(PCSel),
    .imm(imm), .regOut0(regOut0), .pcPlus4(pcPlus4), .fault(fault), .state(state)
  );

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];   // expected fetch addresses, in order
  logic [31:0] m_pc;
  logic [31:0] m_iword;
  logic        m_fault;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Next PC from the architectural rules, using wide signed arithmetic then wrapping.
  function automatic void model_next(input logic [1:0] sel, input logic [15:0] im,
                                     input logic [31:0] rbase, input logic [31:0] pc,
                                     output logic [31:0] tgt, output logic bad);
    longint off;
    longint t;
    off = longint'($signed(im)) * 4;
    case (sel)
      2'd0:    t = longint'(pc) + 4;
      2'd1:    t = longint'(pc) + 4 + off;
      2'd2:    t = longint'(rbase) + off;
      default: t = longint'(pc);
    endcase
    tgt = t[31:0];
    bad = (sel == 2'd3) || ((tgt % 4) != 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imemAck   = 1'b0;
    imemData  = 32'd0;
    instrDone = 1'b0;
    PCSel     = 2'd0;
    imm       = 16'd0;
    regOut0   = 32'd0;
  endtask

  // Leaves the bench at the falling edge of the first REQ cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    check_val("rst_addr", imemAddr, RESET_PC);
    check_val("rst_pcplus4", pcPlus4, RESET_PC + 32'd4);
    check_val("rst_iword", iword, 32'd0);
    check_val("rst_valid", iwordValid, 1'b0);
    check_val("rst_req", imemReq, 1'b0);
    check_val("rst_fault", fault, 1'b0);
    check_val("rst_state", state, ST_IDLE);
    @(negedge clk);
    reset   = 1'b0;
    m_pc    = RESET_PC;
    m_fault = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    #1;
    check_val("idle_state", state, ST_IDLE);
    check_val("idle_req", imemReq, 1'b0);
    tick();
    check_val("first_req", imemReq, 1'b1);
  endtask

  // Called in a REQ cycle; ack arrives in REQ cycle number delay+1.
  task automatic fetch(input logic [31:0] data, input int delay);
    logic [31:0] exp_addr;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 32'd1, 32'd0);
      exp_addr = m_pc;
    end else begin
      exp_addr = exp_q.pop_front();
    end
    check_val("fetch_req", imemReq, 1'b1);
    check_val("fetch_addr", imemAddr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      instrDone = 1'($urandom_range(0, 1));
      PCSel     = 2'd3;
      tick();
      check_val("wait_req", imemReq, 1'b1);
      check_val("wait_addr", imemAddr, exp_addr);
      check_val("wait_fault", fault, 1'b0);
    end
    instrDone = 1'b0;
    PCSel     = 2'd0;
    imemAck   = 1'b1;
    imemData  = data;
    tick();
    imemAck   = 1'b0;
    imemData  = $urandom;
    m_iword   = data;
    check_val("iword", iword, data);
    check_val("iword_valid", iwordValid, 1'b1);
    check_val("issue_req", imemReq, 1'b0);
    check_val("pcplus4", pcPlus4, m_pc + 32'd4);
  endtask

  // Called in an ISSUE cycle; holds for 'hold' cycles, then retires.
  task automatic retire(input logic [1:0] sel, input logic [15:0] im,
                        input logic [31:0] rbase, input int hold);
    logic [31:0] tgt;
    logic        bad;
    for (int i = 0; i < hold; i++) begin
      imemAck  = 1'($urandom_range(0, 1));
      imemData = $urandom;
      tick();
      check_val("hold_iword", iword, m_iword);
      check_val("hold_valid", iwordValid, 1'b1);
      check_val("hold_req", imemReq, 1'b0);
      check_val("hold_pcplus4", pcPlus4, m_pc + 32'd4);
    end
    imemAck   = 1'b0;
    PCSel     = sel;
    imm       = im;
    regOut0   = rbase;
    instrDone = 1'b1;
    model_next(sel, im, rbase, m_pc, tgt, bad);
    tick();
    instrDone = 1'b0;
    PCSel     = 2'(($urandom_range(0, 3)));
    if (bad) begin
      m_fault = 1'b1;
      check_val("flt_set", fault, 1'b1);
      check_val("flt_state", state, ST_HALT);
      check_val("flt_req", imemReq, 1'b0);
      check_val("flt_valid", iwordValid, 1'b0);
      check_val("flt_pc_kept", imemAddr, m_pc);
    end else begin
      m_pc = tgt;
      exp_q.push_back(tgt);
      check_val("next_req", imemReq, 1'b1);
      check_val("next_valid", iwordValid, 1'b0);
      check_val("next_fault", fault, 1'b0);
    end
  endtask

  task automatic halt_check(input int n);
    for (int i = 0; i < n; i++) begin
      imemAck   = 1'($urandom_range(0, 1));
      imemData  = $urandom;
      instrDone = 1'($urandom_range(0, 1));
      PCSel     = 2'd0;
      tick();
      check_val("halt_state", state, ST_HALT);
      check_val("halt_req", imemReq, 1'b0);
      check_val("halt_valid", iwordValid, 1'b0);
      check_val("halt_fault", fault, 1'b1);
      check_val("halt_pc", imemAddr, m_pc);
    end
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    m_pc    = RESET_PC;
    m_fault = 1'b0;
    m_iword = 32'd0;

    // Same-cycle ack at reset PC, then a backward branch.
    do_reset();
    fetch(32'h8000_0001, 0);
    check_val("first_pcplus4", pcPlus4, 32'h44);
    retire(2'd1, 16'hFFFE, 32'd0, 1);
    check_val("branch_back", imemAddr, 32'h3C);

    // JAL from a register base, then wrap-around at the top of memory.
    do_reset();
    fetch($urandom, 2);
    retire(2'd2, 16'h0004, 32'h100, 0);
    check_val("jal_addr", imemAddr, 32'h110);
    fetch($urandom, 1);
    retire(2'd2, 16'h0000, 32'hFFFF_FFFC, 0);
    fetch($urandom, 0);
    check_val("top_pcplus4", pcPlus4, 32'h0);
    retire(2'd0, 16'h0000, 32'd0, 0);
    check_val("wrap_addr", imemAddr, 32'h0);
    check_val("wrap_fault", fault, 1'b0);
    fetch($urandom, 0);
    retire(2'd2, 16'h0000, 32'h101, 0);
    check_val("misalign_fault", fault, 1'b1);
    halt_check(4);

    // Reserved PCSel.
    do_reset();
    fetch($urandom, 0);
    retire(2'd3, 16'h0000, 32'd0, 0);
    halt_check(2);

    // Ack timeout: 16 silent REQ cycles fault, ack in cycle 15 does not.
    do_reset();
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
      tick();
      check_val("to_req", imemReq, 1'b1);
      check_val("to_fault", fault, 1'b0);
    end
    tick();
    m_fault = 1'b1;
    check_val("to_fault_set", fault, 1'b1);
    check_val("to_state", state, ST_HALT);
    check_val("to_req_drop", imemReq, 1'b0);
    halt_check(3);
    do_reset();
    fetch(32'hCAFE_F00D, ACK_TIMEOUT - 2);
    check_val("late_ack_fault", fault, 1'b0);
    retire(2'd0, 16'd0, 32'd0, 0);

    // Asynchronous reset mid-ISSUE and mid-REQ.
    fetch($urandom, 0);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_issue_valid", iwordValid, 1'b0);
    check_val("arst_issue_pc", imemAddr, RESET_PC);
    check_val("arst_issue_req", imemReq, 1'b0);
    do_reset();
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_req_req", imemReq, 1'b0);
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      int r;
      logic [31:0] rb;
      logic [1:0]  sel;
      if (m_fault) begin
        halt_check(2);
        do_reset();
      end
      fetch($urandom, (($urandom_range(0, 7) == 0) ? $urandom_range(0, ACK_TIMEOUT - 1)
                                                    : $urandom_range(0, 3)));
      r  = $urandom_range(0, 12);
      rb = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (r < 4)       sel = 2'd0;
      else if (r < 8)  sel = 2'd1;
      else if (r < 11) sel = 2'd2;
      else if (r == 11) begin
        sel = 2'd2;
        rb  = $urandom;
      end else         sel = 2'd3;
      retire(sel, 16'($urandom), rb, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
